sort_chain_ctrl: RTL

SORT_CHAIN_CTRL -- requirements
Module: sort_chain_ctrl

---
 rtl/sort_chain_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sort_chain_ctrl.sv
// Controller for an insertion-sort cell chain: feeds a batch plus sentinel flush words
// into the chain, discards the chain's first N_CELLS outputs and forwards the sorted rest.
module sort_chain_ctrl #(
    parameter int          N_CELLS  = 8,
    parameter logic [31:0] SENTINEL = 32'h7FFFFFFF
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic        ap_continue,
    input  logic [7:0]  cfg_len,
    input  logic [31:0] src_dout,
    input  logic        src_empty_n,
    output logic        src_read,
    output logic [31:0] chn_din,
    input  logic        chn_full_n,
    output logic        chn_write,
    input  logic [31:0] res_dout,
    input  logic        res_empty_n,
    output logic        res_read,
    output logic [31:0] snk_din,
    input  logic        snk_full_n,
    output logic        snk_write,
    output logic        cell_rst,
    output logic        cell_start,
    output logic        cell_continue
);

    localparam int            CW  = $clog2(2 * N_CELLS + 1);
    localparam logic [CW-1:0] NC  = CW'(N_CELLS);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_CRST  = 6'b000010,
        S_FEED  = 6'b000100,
        S_FLUSH = 6'b001000,
        S_DRAIN = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_flush_cnt;
    logic          r_crst_cnt;

    logic [CW-1:0] w_len_sat;
    logic [CW-1:0] w_total;
    logic          w_active;
    logic          w_out_open;
    logic          w_discard;
    logic          w_src_xfer;
    logic          w_flush_wr;
    logic          w_res_rd;
    logic          w_fwd;

    assign w_len_sat  = (int'(cfg_len) > N_CELLS) ? NC : CW'(cfg_len);
    assign w_total    = NC + r_len;
    assign w_active   = (r_state == S_FEED) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
    assign w_out_open = r_out_cnt < w_total;
    assign w_discard  = r_out_cnt < NC;
    assign w_src_xfer = (r_state == S_FEED) && src_empty_n && chn_full_n;
    assign w_flush_wr = (r_state == S_FLUSH) && chn_full_n;
    // Collection runs beside feeding; warm-up outputs are dropped without waiting for the sink.
    assign w_res_rd   = w_active && w_out_open && res_empty_n && (w_discard || snk_full_n);
    assign w_fwd      = w_active && w_out_open && !w_discard && res_empty_n && snk_full_n;

    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (ap_start) w_next = (cfg_len == 8'd0) ? S_DONE : S_CRST;
            S_CRST:  if (r_crst_cnt) w_next = S_FEED;
            S_FEED:  if (w_src_xfer && (r_in_cnt == r_len - ONE)) w_next = S_FLUSH;
            S_FLUSH: if (w_flush_wr && (r_flush_cnt == NC - ONE)) w_next = S_DRAIN;
            S_DRAIN: if (r_out_cnt == w_total) w_next = S_DONE;
            S_DONE:  if (ap_continue) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_len       <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_flush_cnt <= '0;
            r_crst_cnt  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && ap_start) r_len <= w_len_sat;
            if (r_state == S_CRST) begin
                r_crst_cnt  <= 1'b1;
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_flush_cnt <= '0;
            end else begin
                r_crst_cnt <= 1'b0;
                if (w_src_xfer) r_in_cnt    <= r_in_cnt + ONE;
                if (w_flush_wr) r_flush_cnt <= r_flush_cnt + ONE;
                if (w_res_rd)   r_out_cnt   <= r_out_cnt + ONE;
            end
        end
    end

    always_comb begin
        ap_idle       = 1'b0;
        ap_done       = 1'b0;
        ap_ready      = 1'b0;
        src_read      = 1'b0;
        chn_write     = 1'b0;
        chn_din       = '0;
        res_read      = 1'b0;
        snk_write     = 1'b0;
        snk_din       = '0;
        cell_rst      = 1'b0;
        cell_start    = 1'b0;
        cell_continue = 1'b0;
        unique case (r_state)
            S_IDLE: ap_idle  = 1'b1;
            S_CRST: cell_rst = 1'b1;
            S_FEED: begin
                src_read  = w_src_xfer;
                chn_write = w_src_xfer;
                chn_din   = src_dout;
            end
            S_FLUSH: begin
                chn_write = w_flush_wr;
                chn_din   = SENTINEL;
            end
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ;
        endcase
        if (w_active) begin
            cell_start    = 1'b1;
            cell_continue = 1'b1;
            res_read      = w_res_rd;
            snk_write     = w_fwd;
            snk_din       = w_fwd ? res_dout : '0;
        end
    end

endmodule
